pcie_frame_arbiter: RTL and testbench
=====================================

// Module: pcie_frame_arbiter
// PURPOSE
//  Shares one downstream frame consumer between N_SRC in-order PCIe reassembly streams.
//  Each source presents in-order beats with valid/start/pop and 64-bit address metadata.
//  Grants whole frames round-robin: a frame starts on a start beat and ends after FRAME_BEATS beats.
//  Sits between the per-window reorder buffers and the MSM point loader.
// PARAMETERS
//  N_SRC        4     number of requesting streams (2..8)
//  W            512   beat data width
//  FRAME_BEATS  64    beats per frame; counter width $clog2(FRAME_BEATS+1)
//  TIMEOUT      1024  idle cycles mid-frame before abort (used only with PCIE_ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1            single clock
//  rst_n      in   1            asynchronous active-low reset
//  in_v       in   N_SRC        per-source beat valid
//  in_s       in   N_SRC        per-source beat is frame start
//  in_p       out  N_SRC        per-source pop; beat consumed when in_v&in_p
//  in_a       in   N_SRC*64     per-source beat address
//  in_d       in   N_SRC*W      per-source beat data
//  out_v      out  1            registered output valid
//  out_s      out  1            output beat is frame start
//  out_p      in   1            downstream accepts when out_v&out_p
//  out_a      out  64           output beat address
//  out_d      out  W            output beat data
//  out_src    out  $clog2(N_SRC)  source index of current output beat
//  busy       out  1            frame in progress
//  sync_drop  out  1            1-cycle pulse: non-start beat discarded while IDLE
//  err        out  1            1-cycle pulse: frame aborted by timeout (0 without macro)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr pointer 0; beat count 0; in_p 0.
//  Output stage: one register; load when ~out_v|out_p; latency in->out 1 cycle; full throughput.
//  in_p[g] = (g==grant) & state==ACTIVE & in_v[g] & load & ~(in_s[g] & cnt!=0).
//  FSM IDLE:
//   - Candidates are sources with in_v&in_s.
//   - Pick first candidate at or after rr_ptr (wrap mod N_SRC); grant=it; cnt=0; ->ACTIVE.
//   - Grant decision takes 1 cycle; first beat is popped the next cycle.
//   - Any source with in_v&~in_s is popped and discarded: sync_drop=1 that cycle.
//   - Several discards in one cycle still give one pulse.
//  FSM ACTIVE:
//   - Each popped beat loads the output register and increments cnt.
//   - out_s reflects in_s of the beat.
//   - When cnt reaches FRAME_BEATS on a pop: ->IDLE; rr_ptr=grant+1 (wrap).
//   - If the granted source presents in_s while cnt!=0, that beat is not popped.
//     The frame ends short: ->IDLE, rr_ptr=grant+1; the beat competes next arbitration.
//   - Non-granted sources see in_p=0; their beats wait.
//  Back-pressure: out_v&~out_p holds the register and all in_p=0; the frame stays granted.
//  busy = state==ACTIVE.
//  rst_n assertion mid-frame: immediate return to reset values; partial frame is not flushed.
//  N_SRC index arithmetic wraps modulo N_SRC; N_SRC need not be a power of two.
// CONFIGURATION
//  PCIE_ARB_TIMEOUT_EN defined:
//   - An idle counter runs in ACTIVE while the granted source has in_v=0.
//   - It clears on any pop.
//   - When it reaches TIMEOUT: err=1 for 1 cycle, ->IDLE, rr_ptr=grant+1.
//  Macro undefined: no counter; err tied 0; a stalled source holds its grant indefinitely.
// STRUCTURE
//  pcie_arb_pkg: state_t enum {IDLE,ACTIVE}; beat_t struct {s,a[63:0],d[W-1:0]}.
//  pcie_arb_pkg: function rr_pick(req,ptr) returning index + found flag.
//  Sub-module rr_picker: combinational round-robin first-one-from-pointer, parameter N_SRC.
//  Output register and FSM stay in the top module.
// TESTING
//  1 Src0 sends start + 63 beats, out_p=1 -> 64 beats out, out_src=0.
//    First out_v 2 cycles after in_v; busy drops after beat 64.
//  2 Src0..3 all hold start beats -> frames granted in order 0,1,2,3,0.
//    rr_ptr advances after each frame; no beat interleaving.
//  3 Src1 granted, src1 sends start after 10 beats -> frame ends at cnt=10.
//    Next grant goes to src2 if it is pending, else src1 restarts.
//  4 IDLE, src2 presents a non-start beat -> in_p[2]=1, sync_drop pulse, out_v stays 0.
//  5 out_p toggles 1/0 mid-frame -> no lost or duplicated beats; data equals the source sequence.
//  6 Macro on, TIMEOUT=16, granted src stalls after 5 beats -> err pulse at idle cycle 16.
//    Arbiter moves to next requester; rst_n low mid-frame clears out_v within the same cycle.

Source files
------------

// File: rtl/pcie_arb_pkg.sv
// Shared types and the round-robin search helper for the PCIe frame arbiter.
// rr_pick is written for up to MAX_SRC requesters; callers zero-extend narrower vectors.
package pcie_arb_pkg;

  localparam int MAX_SRC = 8;
  localparam int PTR_W   = 3;
  localparam int DEF_W   = 512;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  typedef struct packed {
    logic             s;
    logic [63:0]      a;
    logic [DEF_W-1:0] d;
  } beat_t;

  typedef struct packed {
    logic             found;
    logic [PTR_W-1:0] idx;
  } pick_t;

  // First set bit of req at or after ptr, wrapping modulo n (n need not be a power of two).
  function automatic pick_t rr_pick(input logic [MAX_SRC-1:0] req,
                                    input logic [PTR_W-1:0]   ptr,
                                    input int                 n);
    pick_t            r;
    logic [PTR_W-1:0] j;
    r = '0;
    for (int k = 0; k < MAX_SRC; k++) begin
      j = PTR_W'((int'(ptr) + k) % n);
      if (k < n && !r.found && req[j]) begin
        r.found = 1'b1;
        r.idx   = j;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pcie_frame_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after the pointer.
module rr_picker
  import pcie_arb_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int IW    = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    idx,
  output logic             found
);

  pick_t p;

  always_comb begin
    p     = rr_pick(MAX_SRC'(req), PTR_W'(ptr), N_SRC);
    idx   = IW'(p.idx);
    found = p.found;
  end

endmodule

// File: rtl/pcie_frame_arbiter.sv
// Round-robin whole-frame arbiter between N_SRC in-order beat streams and one consumer.
// Optional mid-frame stall timeout enabled with `define PCIE_ARB_TIMEOUT_EN.
module pcie_frame_arbiter
  import pcie_arb_pkg::*;
#(
  parameter int N_SRC       = 4,
  parameter int W           = DEF_W,
  parameter int FRAME_BEATS = 64,
  parameter int TIMEOUT     = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_SRC-1:0]         in_v,
  input  logic [N_SRC-1:0]         in_s,
  output logic [N_SRC-1:0]         in_p,
  input  logic [N_SRC*64-1:0]      in_a,
  input  logic [N_SRC*W-1:0]       in_d,
  output logic                     out_v,
  output logic                     out_s,
  input  logic                     out_p,
  output logic [63:0]              out_a,
  output logic [W-1:0]             out_d,
  output logic [$clog2(N_SRC)-1:0] out_src,
  output logic                     busy,
  output logic                     sync_drop,
  output logic                     err
);

  localparam int IW = $clog2(N_SRC);
  localparam int CW = $clog2(FRAME_BEATS + 1);

  if (N_SRC < 2 || N_SRC > MAX_SRC || FRAME_BEATS < 1 || TIMEOUT < 1) begin : g_bad_params
    $error("pcie_frame_arbiter: parameter out of range");
  end

  state_t          state, state_nxt;
  logic [IW-1:0]   grant, grant_nxt, grant_inc;
  logic [IW-1:0]   rr_ptr, rr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [IW-1:0]   pick_idx;
  logic            pick_found;
  logic            load, pop, timeout_hit;
  logic [63:0]     src_a [N_SRC];
  logic [W-1:0]    src_d [N_SRC];

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      src_a[i] = in_a[i*64 +: 64];
      src_d[i] = in_d[i*W +: W];
    end
  end

  rr_picker #(.N_SRC(N_SRC), .IW(IW)) u_rr_picker (
    .req   (in_v & in_s),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign load      = ~out_v | out_p;
  assign grant_inc = (grant == IW'(N_SRC - 1)) ? '0 : grant + 1'b1;
  assign busy      = (state == ACTIVE);

`ifdef PCIE_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;

  assign timeout_hit = (state == ACTIVE) && !in_v[grant] && (idle_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= timeout_hit;
      if (state != ACTIVE || pop || timeout_hit)
        idle_cnt <= '0;
      else if (!in_v[grant])
        idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    cnt_nxt   = cnt;
    in_p      = '0;
    pop       = 1'b0;
    sync_drop = 1'b0;
    case (state)
      IDLE: begin
        // mid-frame beats with no owner are discarded so streams resynchronise on a start
        in_p      = in_v & ~in_s;
        sync_drop = |(in_v & ~in_s);
        if (pick_found) begin
          state_nxt = ACTIVE;
          grant_nxt = pick_idx;
          cnt_nxt   = '0;
        end
      end
      ACTIVE: begin
        if (in_v[grant] && in_s[grant] && cnt != '0) begin
          // early start: close this frame, the start beat re-arbitrates
          state_nxt = IDLE;
          rr_nxt    = grant_inc;
        end else if (in_v[grant] && load) begin
          pop         = 1'b1;
          in_p[grant] = 1'b1;
          cnt_nxt     = cnt + 1'b1;
          if (cnt + 1'b1 == CW'(FRAME_BEATS)) begin
            state_nxt = IDLE;
            rr_nxt    = grant_inc;
            cnt_nxt   = '0;
          end
        end else if (timeout_hit) begin
          state_nxt = IDLE;
          rr_nxt    = grant_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v   <= 1'b0;
      out_s   <= 1'b0;
      out_a   <= '0;
      out_d   <= '0;
      out_src <= '0;
    end else if (load) begin
      out_v <= pop;
      if (pop) begin
        out_s   <= in_s[grant];
        out_a   <= src_a[grant];
        out_d   <= src_d[grant];
        out_src <= grant;
      end
    end
  end

endmodule

// File: tb/tb_pcie_frame_arbiter.sv
// Directed bench for pcie_frame_arbiter; each source streams beats tagged with its index and sequence number.
module tb_pcie_frame_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int FB = 64;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    in_v, in_s, in_p;
  logic [N*64-1:0] in_a;
  logic [N*W-1:0]  in_d;
  logic            out_v, out_s, out_p;
  logic [63:0]     out_a;
  logic [W-1:0]    out_d;
  logic [1:0]      out_src;
  logic            busy, sync_drop, err;

  pcie_frame_arbiter #(.N_SRC(N), .W(W), .FRAME_BEATS(FB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_v(in_v), .in_s(in_s), .in_p(in_p), .in_a(in_a), .in_d(in_d),
    .out_v(out_v), .out_s(out_s), .out_p(out_p), .out_a(out_a), .out_d(out_d),
    .out_src(out_src), .busy(busy), .sync_drop(sync_drop), .err(err)
  );

  always #5 clk = ~clk;

  int seq [N];
  int flen[N] = '{64, 64, 64, 64};
  int lim [N];
  bit en  [N];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      in_v[k]            = en[k] && (seq[k] < lim[k]);
      in_s[k]            = (seq[k] % flen[k]) == 0;
      in_a[k*64 +: 64]   = {32'(k), 32'(seq[k])};
      in_d[k*W +: W]     = {8'(k), 24'(seq[k])};
    end
  end

  typedef struct {
    int src;
    int sq;
    bit s;
  } exp_t;
  exp_t q[$];

  int vectors = 0;
  int miscompares = 0;
  logic         s_err, s_busy, s_ov, s_drop;
  logic [N-1:0] s_inp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int src, input int from, input int n);
    for (int i = 0; i < n; i++)
      q.push_back('{src, from + i, ((from + i) % flen[src]) == 0});
  endtask

  // one clock: snapshot at negedge, score any output transfer, then advance sources that were popped
  task automatic step();
    logic [N-1:0] pops;
    exp_t e;
    @(negedge clk);
    s_err  = err;
    s_busy = busy;
    s_ov   = out_v;
    s_drop = sync_drop;
    s_inp  = in_p;
    pops   = in_v & in_p;
    if (out_v && out_p) begin
      vectors++;
      assert (q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_beat observed=%0h expected=none", out_d);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("beat_d",   64'(out_d),   64'({8'(e.src), 24'(e.sq)}));
        chk("beat_a",   out_a,        {32'(e.src), 32'(e.sq)});
        chk("beat_src", 64'(out_src), 64'(e.src));
        chk("beat_s",   64'(out_s),   64'(e.s));
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++)
      if (pops[k]) seq[k]++;
  endtask

  task automatic drain(input string tag, input int bound);
    int n = 0;
    while (q.size() != 0 && n < bound) begin
      step();
      n++;
    end
    chk({tag, "_left"}, 64'(q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    out_p = 1'b1;
    for (int k = 0; k < N; k++) begin
      en[k]   = 1'b0;
      seq[k]  = 0;
      flen[k] = 64;
      lim[k]  = 0;
    end
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    out_p = 1'b1;
    for (int k = 0; k < N; k++) begin
      en[k] = 1'b0; seq[k] = 0; lim[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_v",     64'(out_v),     64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_in_p",      64'(in_p),      64'd0);
    chk("rst_sync_drop", 64'(sync_drop), 64'd0);
    chk("rst_err",       64'(err),       64'd0);
    chk("rst_out_src",   64'(out_src),   64'd0);
    rst_n = 1'b1;

    // single full frame from src0
    lim[0] = 64; en[0] = 1'b1;
    push(0, 0, 64);
    step();
    chk("t1_ov_c0", 64'(s_ov), 64'd0);
    chk("t1_busy_c0", 64'(s_busy), 64'd0);
    chk("t1_inp_c0", 64'(s_inp), 64'd0);
    step();
    chk("t1_ov_c1", 64'(s_ov), 64'd0);
    chk("t1_busy_c1", 64'(s_busy), 64'd1);
    chk("t1_inp_c1", 64'(s_inp), 64'b0001);
    step();
    chk("t1_ov_c2", 64'(s_ov), 64'd1);
    drain("t1", 200);
    chk("t1_busy_end", 64'(busy), 64'd0);
    chk("t1_ov_end", 64'(out_v), 64'd0);

    // all four request: frames 0,1,2,3 then 0 again
    do_reset();
    lim[0] = 128; lim[1] = 64; lim[2] = 64; lim[3] = 64;
    for (int k = 0; k < N; k++) en[k] = 1'b1;
    push(0, 0, 64); push(1, 0, 64); push(2, 0, 64); push(3, 0, 64); push(0, 64, 64);
    drain("t2", 1000);
    step();
    chk("t2_busy_end", 64'(s_busy), 64'd0);

    // src1 frame cut short by an early start; src2 next, then src1 restarts
    do_reset();
    flen[1] = 10; lim[1] = 21; lim[2] = 64;
    en[1] = 1'b1; en[2] = 1'b1;
    push(1, 0, 10); push(2, 0, 64); push(1, 10, 10); push(1, 20, 1);
    drain("t3", 500);
`ifndef PCIE_ARB_TIMEOUT_EN
    repeat (5) step();
    chk("t3_stall_busy", 64'(s_busy), 64'd1);
    chk("t3_stall_ov", 64'(s_ov), 64'd0);
`endif

    // non-start beats while idle are discarded with one sync_drop pulse per cycle
    do_reset();
    seq[2] = 5; lim[2] = 6; en[2] = 1'b1;
    step();
    chk("t4_inp", 64'(s_inp), 64'b0100);
    chk("t4_drop", 64'(s_drop), 64'd1);
    chk("t4_ov", 64'(s_ov), 64'd0);
    step();
    chk("t4_drop_clear", 64'(s_drop), 64'd0);
    chk("t4_busy", 64'(s_busy), 64'd0);
    chk("t4_seq2", 64'(seq[2]), 64'd6);
    seq[1] = 3; lim[1] = 4; en[1] = 1'b1;
    seq[3] = 7; lim[3] = 8; en[3] = 1'b1;
    step();
    chk("t4_multi_inp", 64'(s_inp), 64'b1010);
    chk("t4_multi_drop", 64'(s_drop), 64'd1);
    step();
    chk("t4_multi_clear", 64'(s_drop), 64'd0);
    chk("t4_multi_ov", 64'(s_ov), 64'd0);

    // downstream back-pressure toggling every cycle
    do_reset();
    lim[0] = 64; en[0] = 1'b1;
    push(0, 0, 64);
    for (int n = 0; n < 400 && q.size() != 0; n++) begin
      out_p = (n % 2) == 0;
      step();
    end
    chk("t5_left", 64'(q.size()), 64'd0);
    out_p = 1'b1;

    // reset asserted mid-frame clears the output at once
    do_reset();
    lim[0] = 64; en[0] = 1'b1;
    push(0, 0, 64);
    repeat (10) step();
    chk("t7_ov_before", 64'(out_v), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t7_ov_rst", 64'(out_v), 64'd0);
    chk("t7_busy_rst", 64'(busy), 64'd0);

    // granted source stalls after 5 beats while src1 waits
    do_reset();
    lim[0] = 5; lim[1] = 64; en[0] = 1'b1; en[1] = 1'b1;
    push(0, 0, 5);
    drain("t6", 50);
`ifdef PCIE_ARB_TIMEOUT_EN
    for (int j = 1; j <= 15; j++) begin
      step();
      chk("t6_err_early", 64'(s_err), 64'd0);
    end
    step();
    chk("t6_err_pulse", 64'(s_err), 64'd1);
    chk("t6_busy_after", 64'(s_busy), 64'd0);
    step();
    chk("t6_err_clear", 64'(s_err), 64'd0);
    chk("t6_busy_src1", 64'(s_busy), 64'd1);
    chk("t6_inp_src1", 64'(s_inp), 64'b0010);
    push(1, 1, 63);
    q.push_front('{1, 0, 1'b1});
    repeat (4) step();
    chk("t6_ov_before", 64'(out_v), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_ov_rst", 64'(out_v), 64'd0);
    q.delete();
`else
    repeat (30) step();
    chk("t6_hold_busy", 64'(s_busy), 64'd1);
    chk("t6_hold_err", 64'(s_err), 64'd0);
    chk("t6_hold_inp", 64'(s_inp), 64'd0);
    chk("t6_hold_ov", 64'(s_ov), 64'd0);
`endif

    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
